// File: rtl/dht11_sensor_emu.sv
// DHT11 sensor-side emulator: answers a host start pulse with the response preamble and a 40-bit frame.
// Optional DHT11_EMU_FAULT_EN adds fault_sel[1:0] for crc corruption, no-response and mid-frame abort.
module dht11_sensor_emu #(
    parameter int unsigned CYC_PER_US    = 100,
    parameter int unsigned START_MIN_US  = 10000,
    parameter int unsigned RESP_DELAY_US = 30,
    parameter int unsigned COOLDOWN_US   = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    inout  wire        dht_data,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_float,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_float,
`ifdef DHT11_EMU_FAULT_EN
    input  logic [1:0] fault_sel,
`endif
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned TW        = 27;
    localparam int unsigned FRAME_W   = 40;
    localparam int unsigned CNT_W     = 6;
    localparam int unsigned START_CYC = START_MIN_US * CYC_PER_US;
    localparam int unsigned DELAY_CYC = RESP_DELAY_US * CYC_PER_US;
    localparam int unsigned RESP_CYC  = 80 * CYC_PER_US;
    localparam int unsigned LOW_CYC   = 50 * CYC_PER_US;
    localparam int unsigned ZERO_CYC  = 27 * CYC_PER_US;
    localparam int unsigned ONE_CYC   = 70 * CYC_PER_US;
    localparam int unsigned COOL_CYC  = COOLDOWN_US * CYC_PER_US;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HOST_LOW,
        S_HOST_REL,
        S_RESP_LOW,
        S_RESP_HIGH,
        S_BIT_LOW,
        S_BIT_HIGH,
        S_END_LOW,
        S_COOLDOWN
    } state_t;

    state_t               state, state_nxt;
    logic [TW-1:0]        timer;
    logic                 sync1, sync2, sync_d;
    logic [FRAME_W-1:0]   shreg;
    logic [CNT_W-1:0]     bit_cnt;
    logic [1:0]           fault_q, fault_c;
    logic [7:0]           crc_c;
    logic                 drive, drive_nxt, busy_nxt;
    logic                 latch_c, shift_c, done_c;

`ifdef DHT11_EMU_FAULT_EN
    assign fault_c = fault_sel;
`else
    assign fault_c = 2'b00;
`endif

    assign crc_c    = 8'(hum_int + hum_float + temp_int + temp_float) ^ {7'd0, fault_c == 2'b01};
    assign dht_data = drive ? 1'b0 : 1'bz;

    // State register and single per-state timer, cleared on every transition and saturating
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            state <= S_IDLE;
            timer <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                timer <= '0;
            end else if (timer != '1) begin
                timer <= timer + TW'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        latch_c   = 1'b0;
        shift_c   = 1'b0;
        done_c    = 1'b0;
        case (state)
            S_IDLE: begin
                if (sync_d && !sync2) state_nxt = S_HOST_LOW;
            end
            S_HOST_LOW: begin
                if (sync2) state_nxt = (timer >= TW'(START_CYC)) ? S_HOST_REL : S_IDLE;
            end
            S_HOST_REL: begin
                if (timer == TW'(DELAY_CYC - 1)) begin
                    latch_c   = 1'b1;
                    state_nxt = (fault_c == 2'b10) ? S_COOLDOWN : S_RESP_LOW;
                end
            end
            S_RESP_LOW: begin
                if (timer == TW'(RESP_CYC - 1)) state_nxt = S_RESP_HIGH;
            end
            S_RESP_HIGH: begin
                if (timer == TW'(RESP_CYC - 1)) state_nxt = S_BIT_LOW;
            end
            S_BIT_LOW: begin
                if (timer == TW'(LOW_CYC - 1)) state_nxt = S_BIT_HIGH;
            end
            S_BIT_HIGH: begin
                // High time encodes the bit value; the abort fault cuts the frame after 20 bits
                if (timer == (shreg[FRAME_W-1] ? TW'(ONE_CYC - 1) : TW'(ZERO_CYC - 1))) begin
                    shift_c = 1'b1;
                    if (fault_q == 2'b11 && bit_cnt == CNT_W'(19)) begin
                        state_nxt = S_COOLDOWN;
                    end else if (bit_cnt == CNT_W'(FRAME_W - 1)) begin
                        state_nxt = S_END_LOW;
                    end else begin
                        state_nxt = S_BIT_LOW;
                    end
                end
            end
            S_END_LOW: begin
                if (timer == TW'(LOW_CYC - 1)) begin
                    done_c    = 1'b1;
                    state_nxt = S_COOLDOWN;
                end
            end
            S_COOLDOWN: begin
                if (timer == TW'(COOL_CYC - 1)) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        drive_nxt = (state_nxt == S_RESP_LOW) || (state_nxt == S_BIT_LOW) || (state_nxt == S_END_LOW);
        busy_nxt  = (state_nxt != S_IDLE) && (state_nxt != S_HOST_LOW);
    end

    // Bus synchronizer, frame shift register and registered outputs
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            sync_d     <= 1'b1;
            shreg      <= '0;
            bit_cnt    <= '0;
            fault_q    <= '0;
            drive      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            sync1      <= dht_data;
            sync2      <= sync1;
            sync_d     <= sync2;
            drive      <= drive_nxt;
            busy       <= busy_nxt;
            frame_done <= done_c;
            if (latch_c) begin
                shreg   <= {hum_int, hum_float, temp_int, temp_float, crc_c};
                bit_cnt <= '0;
                fault_q <= fault_c;
            end else if (shift_c) begin
                shreg   <= {shreg[FRAME_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dht11_sensor_emu.sv
// Directed/randomized bench for dht11_sensor_emu: decodes the bus waveform and compares against a frame model.
module tb_dht11_sensor_emu;

    localparam int unsigned CYC      = 1;
    localparam int unsigned START_US = 100;
    localparam int unsigned DELAY_US = 30;
    localparam int unsigned COOL_US  = 200;
    localparam int RESP_W = 80 * CYC;
    localparam int BLOW_W = 50 * CYC;
    localparam int B0_W   = 27 * CYC;
    localparam int B1_W   = 70 * CYC;
    localparam int END_W  = 50 * CYC;
    localparam int COOL_W = COOL_US * CYC;
    localparam int LAT    = DELAY_US * CYC + 3;

    logic       clk = 1'b0;
    logic       rst, en, host_low;
    logic [7:0] hi, hf, ti, tf;
    logic       busy, frame_done;
    wire        dht_data;

    int errors = 0;
    int checks = 0;
    int fd_seen;
    int hw[40];

    always #5 clk = ~clk;

    assign dht_data = host_low ? 1'b0 : 1'bz;
    pullup (dht_data);

    dht11_sensor_emu #(
        .CYC_PER_US(CYC), .START_MIN_US(START_US),
        .RESP_DELAY_US(DELAY_US), .COOLDOWN_US(COOL_US)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .dht_data(dht_data),
        .hum_int(hi), .hum_float(hf), .temp_int(ti), .temp_float(tf),
        .busy(busy), .frame_done(frame_done)
    );

    initial begin
        #5ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Width in cycles of the level currently on the bus; returns on the first sample of the other level
    task automatic measure(input logic lvl, output int w, inout bit tout);
        bit stop;
        stop = 1'b0;
        w = 1;
        while (!stop) begin
            @(negedge clk);
            fd_seen += (frame_done === 1'b1) ? 1 : 0;
            if (dht_data !== lvl) stop = 1'b1;
            else begin
                w++;
                if (w > 1000) begin tout = 1'b1; stop = 1'b1; end
            end
        end
    endtask

    task automatic host_start(input int len);
        @(negedge clk);
        host_low = 1'b1;
        repeat (len) @(negedge clk);
        host_low = 1'b0;
    endtask

    task automatic wait_response(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (dht_data !== 1'b0 && lat < 500);
    endtask

    task automatic wait_idle(input string tag, input int exp_n);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== 1'b0 && n < 2000);
        check({tag, " cooldown_len"}, 64'(n), 64'(exp_n));
    endtask

    task automatic run_frame(input logic [7:0] a, b, c, d, input int host_len,
                             input bit scramble, input bit do_idle, input string tag);
        logic [7:0]  crc;
        logic [39:0] exp, data;
        int          lat, w, bad_low, bad_high;
        bit          tout, bitv;
        crc = a + b + c + d;
        exp = {a, b, c, d, crc};
        hi = a; hf = b; ti = c; tf = d;
        fd_seen = 0; tout = 1'b0; bad_low = 0; bad_high = 0; data = '0;
        host_start(host_len);
        wait_response(lat);
        check({tag, " latency"}, 64'(lat), 64'(LAT));
        check({tag, " busy"}, 64'(busy), 64'(1));
        if (scramble) begin
            hi = 8'($urandom); hf = 8'($urandom); ti = 8'($urandom); tf = 8'($urandom);
        end
        measure(1'b0, w, tout);
        check({tag, " resp_low"}, 64'(w), 64'(RESP_W));
        measure(1'b1, w, tout);
        check({tag, " resp_high"}, 64'(w), 64'(RESP_W));
        for (int i = 0; i < 40; i++) begin
            measure(1'b0, w, tout);
            if (w != BLOW_W) bad_low++;
            measure(1'b1, w, tout);
            hw[i] = w;
            bitv  = (w > (B0_W + B1_W) / 2);
            data  = {data[38:0], bitv};
            if (w != (bitv ? B1_W : B0_W)) bad_high++;
        end
        measure(1'b0, w, tout);
        check({tag, " end_low"}, 64'(w), 64'(END_W));
        check({tag, " frame_done_at_release"}, 64'(frame_done), 64'(1));
        check({tag, " frame_done_count"}, 64'(fd_seen), 64'(1));
        check({tag, " data"}, 64'(data), 64'(exp));
        check({tag, " bit_low_widths"}, 64'(bad_low), 64'(0));
        check({tag, " bit_high_widths"}, 64'(bad_high), 64'(0));
        check({tag, " timeout"}, 64'(tout), 64'(0));
        if (do_idle) wait_idle(tag, COOL_W);
    endtask

    initial begin
        int  w, lat, bad;
        bit  tout;
        rst = 1'b1; en = 1'b1; host_low = 1'b0;
        hi = '0; hf = '0; ti = '0; tf = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'(0));
        check("reset frame_done", 64'(frame_done), 64'(0));
        check("reset bus", 64'(dht_data), 64'(1));
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Reference vector, inputs changed after latching
        run_frame(8'h37, 8'h00, 8'h19, 8'h05, 150, 1'b1, 1'b1, "vec37");
        // MSB one then zero on the first two bits
        run_frame(8'h80, 8'h00, 8'h00, 8'h00, 150, 1'b0, 1'b1, "vec80");
        check("vec80 bit0_high", 64'(hw[0]), 64'(B1_W));
        check("vec80 bit1_high", 64'(hw[1]), 64'(B0_W));
        run_frame(8'h2A, 8'h01, 8'h1C, 8'h00, 150, 1'b0, 1'b1, "vec2a");
        for (int k = 0; k < 2; k++)
            run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 150, 1'b1, 1'b1, "rand");

        // Short host pulse is ignored
        host_start(98);
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (dht_data === 1'b0 || busy === 1'b1) bad++;
        end
        check("short_pulse ignored", 64'(bad), 64'(0));
        // Just above the minimum start length is accepted
        run_frame(8'($urandom), 8'hFF, 8'hFF, 8'($urandom), 104, 1'b0, 1'b1, "min_start");

        // Reset during bit 12
        host_start(150);
        wait_response(lat);
        fd_seen = 0; tout = 1'b0;
        measure(1'b0, w, tout);
        measure(1'b1, w, tout);
        for (int i = 0; i < 12; i++) begin
            measure(1'b0, w, tout);
            measure(1'b1, w, tout);
        end
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midreset bus", 64'(dht_data), 64'(1));
        check("midreset busy", 64'(busy), 64'(0));
        rst = 1'b0;
        repeat (5) @(negedge clk);
        run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 150, 1'b0, 1'b1, "after_reset");

        // Start pulse during cooldown is ignored
        run_frame(8'h11, 8'h22, 8'h33, 8'h44, 150, 1'b0, 1'b0, "pre_cool");
        repeat (20) @(negedge clk);
        host_start(150);
        bad = 0; w = 0;
        do begin
            @(negedge clk);
            w++;
            if (dht_data === 1'b0) bad++;
        end while (busy !== 1'b0 && w < 2000);
        check("cooldown start ignored", 64'(bad), 64'(0));
        check("cooldown busy drop", 64'(busy), 64'(0));
        repeat (30) @(negedge clk);
        check("cooldown no late response", 64'(busy), 64'(0));
        run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 150, 1'b0, 1'b1, "post_cool");

        // Disable mid-response
        host_start(150);
        wait_response(lat);
        repeat (10) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("disable bus", 64'(dht_data), 64'(1));
        check("disable busy", 64'(busy), 64'(0));
        en = 1'b1;
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dht11_sensor_emu.md
Name: dht11_sensor_emu

Overview:
- Single-wire DHT11 responder: emulates the sensor end of the DHT11 bus so the existing DHT11 reader can be exercised in simulation and on-board loopback without a physical sensor.
- Detects the host start pulse, then transmits the response preamble and a 40-bit frame.
- Frame contents: humidity int/frac, temperature int/frac and checksum, built from parallel input values.
- Drives the bus open-drain only: pulls low or releases; the external or bench pull-up supplies the high level.

Parameters:
- CYC_PER_US, 100, clock cycles per microsecond (100 MHz system clock).
- START_MIN_US, 10000, minimum host low time accepted as a start request.
- RESP_DELAY_US, 30, wait after host releases before the sensor pulls low.
- COOLDOWN_US, 1000, bus-ignore time after each frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  block enable; low means the block returns to IDLE and releases the bus.
- dht_data  inout  1  DHT bus; driven 1'b0 when pulling low, 'bz otherwise.
- hum_int  in  8  humidity integer byte.
- hum_float  in  8  humidity fraction byte.
- temp_int  in  8  temperature integer byte.
- temp_float  in  8  temperature fraction byte.
- busy  out  1  high from start-pulse acceptance until cooldown ends.
- frame_done  out  1  one-cycle pulse when the final bit has finished.

Behaviour:
- Reset (rst=1 at posedge clk): state IDLE, bus released, busy=0, frame_done=0, all counters 0. Applies immediately mid-frame; no partial pulse is stretched.
- Bus input passes through a 2-FF synchronizer; all timing is measured on the synchronized value, which adds 2 cycles of latency.
- Single timer counter, 27 bits, cleared on every state change. All durations are N*CYC_PER_US cycles.
- IDLE: bus released. A synchronized falling edge goes to HOST_LOW.
- HOST_LOW: count low time.
  - Line returns high before START_MIN_US: IDLE (glitch or short pulse ignored).
  - Line high at or after START_MIN_US: HOST_REL and busy=1.
  - Line held low indefinitely: remain in HOST_LOW with the timer saturated.
- HOST_REL: wait RESP_DELAY_US, then latch the four input bytes and crc = (hum_int+hum_float+temp_int+temp_float) mod 256 into a 40-bit shift register. Byte order: hum_int, hum_float, temp_int, temp_float, crc; MSB first. Next state RESP_LOW.
- RESP_LOW: pull low 80 us, then RESP_HIGH.
- RESP_HIGH: release 80 us, then BIT_LOW with bit count 0.
- BIT_LOW: pull low 50 us, then BIT_HIGH.
- BIT_HIGH: release 27 us if the current bit is 0, 70 us if it is 1.
  - Then shift and increment the bit count.
  - If 40 bits have been sent: END_LOW. Otherwise: BIT_LOW.
- END_LOW: pull low 50 us, release, assert frame_done for one cycle, go to COOLDOWN.
- COOLDOWN: bus released, input ignored for COOLDOWN_US, then IDLE with busy=0.
- Input bytes may change during a frame; the frame uses the values latched in HOST_REL.
- Bus is not monitored from RESP_LOW to END_LOW; contention is not detected.
- en=0 in any state is equivalent to reset, except that it is not a reset input.

Optional Feature:
- Macro DHT11_EMU_FAULT_EN adds input port fault_sel[1:0]; the value is sampled in HOST_REL.
  - 00: normal frame.
  - 01: crc LSB inverted.
  - 10: no response; the block goes straight to COOLDOWN, so the reader sees a timeout.
  - 11: frame aborted after 20 bits; the bus is released and the block goes to COOLDOWN without asserting frame_done.
- Without the macro: no port, always normal frame.

Test Plan:
- Host drives low 18 ms, releases; inputs 0x37,0x00,0x19,0x05 -> bus low 8000 cycles, high 8000 cycles, 40 bits 0x37 00 19 05 55 MSB-first, frame_done pulse, busy drops 100000 cycles later.
- Bit timing check on 0x80 in hum_int -> first bit high 7000 cycles, second bit high 2700 cycles, every low phase 5000 cycles (±2 cycles sync slack).
- Host low pulse of 5 ms -> no bus drive, busy stays 0, state back to IDLE.
- rst asserted during bit 12 -> bus released on next cycle, busy=0, new 18 ms start yields a complete correct frame.
- Start pulse issued during COOLDOWN -> ignored; repeat after busy=0 -> normal frame.
- Loopback with the existing DHT11 reader at 100 MHz, inputs 0x2A,0x01,0x1C,0x00 -> reader error=0, crc output 0x47, data matches.
